ex_mem_skid_stage: RTL and testbench
====================================

Name: ex_mem_skid_stage

Overview:
- EX→MEM boundary stage of the RV32 pipeline; the consumer end of the execute-stage result interface (alu_result_out / alu_zero_out plus control).
- Registers each EX result behind a valid/ready handshake, with a 2-entry skid buffer so ex_ready_out has no combinational path from mem_ready_in.
- Returns a forwarding view of its youngest held entry to the execute-stage operand mux, and keeps a saturating back-pressure counter.

Parameters:
- DATA_W, 32, width of result, store data and PC.
- CNT_W, 16, width of the back-pressure stall counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush_in  in  1  kill all held and incoming entries
- ex_valid_in  in  1  EX offers an entry
- ex_ready_out  out  1  stage can accept an entry
- alu_result_in  in  DATA_W  ALU result
- alu_zero_in  in  1  ALU zero flag
- store_data_in  in  DATA_W  rs2 value for stores
- pc_in  in  DATA_W  PC of the instruction
- rd_addr_in  in  5  destination register
- reg_write_in  in  1  writes rd
- mem_read_in  in  1  load
- mem_write_in  in  1  store
- mem_valid_out  out  1  head entry valid toward MEM
- mem_ready_in  in  1  MEM accepts head
- mem_alu_result_out, mem_store_data_out, mem_pc_out  out  DATA_W  head payload
- mem_zero_out, mem_reg_write_out, mem_mem_read_out, mem_mem_write_out  out  1  head payload
- mem_rd_addr_out  out  5  head payload
- fwd_valid_out  out  1  youngest entry writes a nonzero rd
- fwd_rd_out  out  5  youngest entry rd
- fwd_data_out  out  DATA_W  youngest entry alu_result
- fwd_is_load_out  out  1  youngest entry is a load; its data is not yet available
- stall_cnt_out  out  CNT_W  back-pressure cycle count

Behaviour:
- Storage: head register H (drives mem_*) and skid register S, each with its own valid bit.
- Handshake events:
  - accept = ex_valid_in & ex_ready_out
  - emit = mem_valid_out & mem_ready_in
- ex_ready_out = !S.valid. This is a pure register decode.
- mem_valid_out = H.valid. This is a pure register decode.
- Latency: an accepted entry appears on mem_* on the next cycle. There is no same-cycle bypass.
- Next-state update, when flush_in=0, by occupancy:
  - Occupancy 0, accept → H = new.
  - Occupancy 1 (H only):
    - accept & emit → H = new.
    - accept & !emit → S = new.
    - emit only → H invalid.
  - Occupancy 2: accept is impossible (ex_ready_out=0).
    - emit → H = S, S invalid.
    - no emit → hold both.
- Entries leave in acceptance order. Payload never changes while H.valid & !mem_ready_in.
- flush_in=1:
  - The head transfer in that cycle still completes if emit.
  - Next cycle H.valid = S.valid = 0. An accept in the flush cycle is discarded.
  - ex_ready_out returns to 1 the next cycle.
- Forwarding selects Y = S if S.valid, else H.
  - fwd_valid_out = Y.valid & Y.reg_write & (Y.rd != 0).
  - fwd_rd_out and fwd_data_out come from Y.
  - fwd_is_load_out = fwd_valid_out & Y.mem_read.
  - With no valid entry, all fwd outputs are 0.
- stall_cnt_out increments each cycle with H.valid & !mem_ready_in.
  - It saturates at all-ones. It is not cleared by flush_in; only reset clears it.
- Reset (async assert, sync-deassert at the system level):
  - H.valid = S.valid = 0 and all payload registers = 0.
  - ex_ready_out = 1, mem_valid_out = 0, fwd_* = 0, stall_cnt_out = 0.
  - Reset mid-transfer drops both entries with no partial output.
- Never accept while S.valid. A bench must flag ex_ready_out=1 with both entries valid.

Test Plan:
- Streaming: mem_ready_in=1 constantly; accept results 0x11, 0x22, 0x33 on consecutive cycles → mem_valid_out stream 0x11, 0x22, 0x33, one cycle later each; ex_ready_out stays 1; stall_cnt_out=0.
- Back-pressure: mem_ready_in=0, accept 0xA then 0xB → ex_ready_out=0 after the second accept; head holds 0xA; raise mem_ready_in → 0xA, then 0xB emitted; stall_cnt_out equals the number of held cycles.
- Flush: two entries held, flush_in=1 with mem_ready_in=1 and ex_valid_in=1 (0xC) → 0xA emitted in the flush cycle; 0xB and 0xC never appear; next cycle mem_valid_out=0, ex_ready_out=1.
- Forwarding: H = rd5/0x100 write, S = rd7 load → fwd_rd_out=7, fwd_is_load_out=1; emit H and move S to H → still rd7; an entry with rd=0 and reg_write=1 → fwd_valid_out=0.
- Counter saturation with CNT_W=4: hold back-pressure for 20 cycles → stall_cnt_out=15.
- Reset: assert rst_n=0 asynchronously mid-cycle with two entries held → mem_valid_out, fwd_valid_out and stall_cnt_out go to 0 immediately; ex_ready_out=1.

Source files
------------

// File: rtl/ex_mem_skid_stage.sv
// EX->MEM pipeline boundary: head/skid register pair behind a valid/ready handshake,
// with a forwarding view of the youngest held entry and a saturating stall counter.
module ex_mem_skid_stage #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush_in,
   input  logic              ex_valid_in,
   output logic              ex_ready_out,
   input  logic [DATA_W-1:0] alu_result_in,
   input  logic              alu_zero_in,
   input  logic [DATA_W-1:0] store_data_in,
   input  logic [DATA_W-1:0] pc_in,
   input  logic [4:0]        rd_addr_in,
   input  logic              reg_write_in,
   input  logic              mem_read_in,
   input  logic              mem_write_in,
   output logic              mem_valid_out,
   input  logic              mem_ready_in,
   output logic [DATA_W-1:0] mem_alu_result_out,
   output logic [DATA_W-1:0] mem_store_data_out,
   output logic [DATA_W-1:0] mem_pc_out,
   output logic              mem_zero_out,
   output logic              mem_reg_write_out,
   output logic              mem_mem_read_out,
   output logic              mem_mem_write_out,
   output logic [4:0]        mem_rd_addr_out,
   output logic              fwd_valid_out,
   output logic [4:0]        fwd_rd_out,
   output logic [DATA_W-1:0] fwd_data_out,
   output logic              fwd_is_load_out,
   output logic [CNT_W-1:0]  stall_cnt_out
);

   typedef struct packed {
      logic [DATA_W-1:0] result;
      logic [DATA_W-1:0] store_data;
      logic [DATA_W-1:0] pc;
      logic [4:0]        rd;
      logic              zero;
      logic              reg_write;
      logic              mem_read;
      logic              mem_write;
   } entry_t;

   entry_t            h_q, h_d, s_q, s_d, new_e, y;
   logic              h_valid_q, h_valid_d, s_valid_q, s_valid_d;
   logic              y_valid, accept, emit;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   assign ex_ready_out  = !s_valid_q;
   assign mem_valid_out = h_valid_q;
   assign accept        = ex_valid_in & ex_ready_out;
   assign emit          = h_valid_q & mem_ready_in;

   always_comb begin
      new_e            = '0;
      new_e.result     = alu_result_in;
      new_e.store_data = store_data_in;
      new_e.pc         = pc_in;
      new_e.rd         = rd_addr_in;
      new_e.zero       = alu_zero_in;
      new_e.reg_write  = reg_write_in;
      new_e.mem_read   = mem_read_in;
      new_e.mem_write  = mem_write_in;
   end

   // S is only ever valid alongside H, so occupancy is decoded from the two valid bits.
   always_comb begin
      h_d       = h_q;
      s_d       = s_q;
      h_valid_d = h_valid_q;
      s_valid_d = s_valid_q;
      if (flush_in) begin
         h_valid_d = 1'b0;
         s_valid_d = 1'b0;
      end else if (s_valid_q) begin
         if (emit) begin
            h_d       = s_q;
            s_valid_d = 1'b0;
         end
      end else if (h_valid_q) begin
         if (accept && emit) begin
            h_d = new_e;
         end else if (accept) begin
            s_d       = new_e;
            s_valid_d = 1'b1;
         end else if (emit) begin
            h_valid_d = 1'b0;
         end
      end else if (accept) begin
         h_d       = new_e;
         h_valid_d = 1'b1;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (h_valid_q && !mem_ready_in && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_q       <= '0;
         s_q       <= '0;
         h_valid_q <= 1'b0;
         s_valid_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         h_q       <= h_d;
         s_q       <= s_d;
         h_valid_q <= h_valid_d;
         s_valid_q <= s_valid_d;
         cnt_q     <= cnt_d;
      end
   end

   assign mem_alu_result_out = h_q.result;
   assign mem_store_data_out = h_q.store_data;
   assign mem_pc_out         = h_q.pc;
   assign mem_zero_out       = h_q.zero;
   assign mem_reg_write_out  = h_q.reg_write;
   assign mem_mem_read_out   = h_q.mem_read;
   assign mem_mem_write_out  = h_q.mem_write;
   assign mem_rd_addr_out    = h_q.rd;

   // Youngest entry is S when present; stale payload is masked when nothing is held.
   assign y               = s_valid_q ? s_q : h_q;
   assign y_valid         = s_valid_q | h_valid_q;
   assign fwd_valid_out   = y_valid & y.reg_write & (y.rd != 5'd0);
   assign fwd_rd_out      = y_valid ? y.rd : 5'd0;
   assign fwd_data_out    = y_valid ? y.result : '0;
   assign fwd_is_load_out = fwd_valid_out & y.mem_read;
   assign stall_cnt_out   = cnt_q;

endmodule

// File: tb/tb_ex_mem_skid_stage.sv
// Directed bench for ex_mem_skid_stage: streaming, back-pressure, flush, forwarding,
// stall-counter saturation (CNT_W=4) and asynchronous reset.
module tb_ex_mem_skid_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush_in, ex_valid_in, ex_ready_out;
   logic [31:0] alu_result_in, store_data_in, pc_in;
   logic        alu_zero_in, reg_write_in, mem_read_in, mem_write_in;
   logic [4:0]  rd_addr_in;
   logic        mem_valid_out, mem_ready_in;
   logic [31:0] mem_alu_result_out, mem_store_data_out, mem_pc_out;
   logic        mem_zero_out, mem_reg_write_out, mem_mem_read_out, mem_mem_write_out;
   logic [4:0]  mem_rd_addr_out;
   logic        fwd_valid_out, fwd_is_load_out;
   logic [4:0]  fwd_rd_out;
   logic [31:0] fwd_data_out;
   logic [3:0]  stall_cnt_out;

   int unsigned n_pass = 0;
   int unsigned n_total = 0;

   always #5 clk = ~clk;

   ex_mem_skid_stage #(.DATA_W(32), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .flush_in(flush_in),
      .ex_valid_in(ex_valid_in), .ex_ready_out(ex_ready_out),
      .alu_result_in(alu_result_in), .alu_zero_in(alu_zero_in),
      .store_data_in(store_data_in), .pc_in(pc_in), .rd_addr_in(rd_addr_in),
      .reg_write_in(reg_write_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
      .mem_valid_out(mem_valid_out), .mem_ready_in(mem_ready_in),
      .mem_alu_result_out(mem_alu_result_out), .mem_store_data_out(mem_store_data_out),
      .mem_pc_out(mem_pc_out), .mem_zero_out(mem_zero_out),
      .mem_reg_write_out(mem_reg_write_out), .mem_mem_read_out(mem_mem_read_out),
      .mem_mem_write_out(mem_mem_write_out), .mem_rd_addr_out(mem_rd_addr_out),
      .fwd_valid_out(fwd_valid_out), .fwd_rd_out(fwd_rd_out), .fwd_data_out(fwd_data_out),
      .fwd_is_load_out(fwd_is_load_out), .stall_cnt_out(stall_cnt_out)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic v, input logic [31:0] res, input logic [4:0] rd,
                        input logic rw, input logic mr);
      ex_valid_in   = v;
      alu_result_in = res;
      store_data_in = res ^ 32'hFFFF_0000;
      pc_in         = res << 2;
      rd_addr_in    = rd;
      reg_write_in  = rw;
      mem_read_in   = mr;
      mem_write_in  = 1'b0;
      alu_zero_in   = (res == 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; flush_in = 1'b0; mem_ready_in = 1'b0;
      offer(1'b0, 32'd0, 5'd0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ex_ready", 32'(ex_ready_out), 32'd1);
      chk("rst_mem_valid", 32'(mem_valid_out), 32'd0);
      chk("rst_fwd_valid", 32'(fwd_valid_out), 32'd0);
      chk("rst_stall", 32'(stall_cnt_out), 32'd0);
      chk("rst_payload", mem_alu_result_out, 32'd0);
      @(negedge clk) rst_n = 1'b1;

      // Streaming at full rate
      mem_ready_in = 1'b1;
      offer(1'b1, 32'h11, 5'd1, 1'b1, 1'b0);
      tick();
      chk("str_v1", 32'(mem_valid_out), 32'd1);
      chk("str_d1", mem_alu_result_out, 32'h11);
      chk("str_pc1", mem_pc_out, 32'h44);
      chk("str_rdy1", 32'(ex_ready_out), 32'd1);
      offer(1'b1, 32'h22, 5'd2, 1'b1, 1'b0);
      tick();
      chk("str_d2", mem_alu_result_out, 32'h22);
      chk("str_rdy2", 32'(ex_ready_out), 32'd1);
      offer(1'b1, 32'h33, 5'd3, 1'b1, 1'b0);
      tick();
      chk("str_d3", mem_alu_result_out, 32'h33);
      chk("str_fwd_rd3", 32'(fwd_rd_out), 32'd3);
      chk("str_fwd_data3", fwd_data_out, 32'h33);
      offer(1'b0, 32'd0, 5'd0, 1'b0, 1'b0);
      tick();
      chk("str_drain", 32'(mem_valid_out), 32'd0);
      chk("str_fwd_empty", 32'(fwd_rd_out), 32'd0);
      chk("str_stall", 32'(stall_cnt_out), 32'd0);

      // Back-pressure and forwarding from the skid entry
      mem_ready_in = 1'b0;
      offer(1'b1, 32'hA, 5'd5, 1'b1, 1'b0);
      tick();
      chk("bp_headA", mem_alu_result_out, 32'hA);
      chk("bp_rdy_after1", 32'(ex_ready_out), 32'd1);
      chk("bp_stall0", 32'(stall_cnt_out), 32'd0);
      offer(1'b1, 32'hB, 5'd7, 1'b1, 1'b1);
      tick();
      chk("bp_rdy_full", 32'(ex_ready_out), 32'd0);
      chk("bp_hold_A", mem_alu_result_out, 32'hA);
      chk("bp_stall1", 32'(stall_cnt_out), 32'd1);
      chk("fwd_rd_skid", 32'(fwd_rd_out), 32'd7);
      chk("fwd_load_skid", 32'(fwd_is_load_out), 32'd1);
      chk("fwd_data_skid", fwd_data_out, 32'hB);
      offer(1'b1, 32'hEE, 5'd9, 1'b1, 1'b0);
      tick();
      chk("bp_hold_A2", mem_alu_result_out, 32'hA);
      chk("bp_stall2", 32'(stall_cnt_out), 32'd2);
      chk("bp_no_accept_full", 32'(ex_ready_out), 32'd0);
      offer(1'b0, 32'd0, 5'd0, 1'b0, 1'b0);
      mem_ready_in = 1'b1;
      tick();
      chk("bp_headB", mem_alu_result_out, 32'hB);
      chk("bp_rdy_again", 32'(ex_ready_out), 32'd1);
      chk("fwd_rd_moved", 32'(fwd_rd_out), 32'd7);
      chk("fwd_load_moved", 32'(fwd_is_load_out), 32'd1);
      tick();
      chk("bp_drained", 32'(mem_valid_out), 32'd0);
      chk("bp_fwd_off", 32'(fwd_valid_out), 32'd0);
      chk("bp_stall_total", 32'(stall_cnt_out), 32'd2);

      // Flush with two held entries; head still transfers in the flush cycle
      mem_ready_in = 1'b0;
      offer(1'b1, 32'hA, 5'd5, 1'b1, 1'b0);
      tick();
      offer(1'b1, 32'hB, 5'd6, 1'b1, 1'b0);
      tick();
      chk("fl_full", 32'(ex_ready_out), 32'd0);
      flush_in = 1'b1; mem_ready_in = 1'b1;
      offer(1'b1, 32'hC, 5'd8, 1'b1, 1'b0);
      #1;
      chk("fl_emit_valid", 32'(mem_valid_out), 32'd1);
      chk("fl_emit_A", mem_alu_result_out, 32'hA);
      tick();
      flush_in = 1'b0; mem_ready_in = 1'b0;
      offer(1'b0, 32'd0, 5'd0, 1'b0, 1'b0);
      chk("fl_empty", 32'(mem_valid_out), 32'd0);
      chk("fl_ready", 32'(ex_ready_out), 32'd1);
      chk("fl_fwd_off", 32'(fwd_valid_out), 32'd0);
      tick();
      chk("fl_still_empty", 32'(mem_valid_out), 32'd0);
      chk("fl_stall_kept", 32'(stall_cnt_out), 32'd3);

      // rd=0 never forwards
      offer(1'b1, 32'h55, 5'd0, 1'b1, 1'b0);
      tick();
      offer(1'b0, 32'd0, 5'd0, 1'b0, 1'b0);
      chk("x0_head", 32'(mem_valid_out), 32'd1);
      chk("x0_fwd_valid", 32'(fwd_valid_out), 32'd0);

      // Saturation: 3 + 12 held cycles reaches 15, further cycles stay there
      repeat (12) tick();
      chk("sat_reach", 32'(stall_cnt_out), 32'd15);
      repeat (8) tick();
      chk("sat_hold", 32'(stall_cnt_out), 32'd15);
      chk("sat_head_stable", mem_alu_result_out, 32'h55);

      // Asynchronous reset mid-cycle with both entries held
      offer(1'b1, 32'h66, 5'd9, 1'b1, 1'b0);
      tick();
      offer(1'b0, 32'd0, 5'd0, 1'b0, 1'b0);
      chk("pre_rst_full", 32'(ex_ready_out), 32'd0);
      chk("pre_rst_fwd", 32'(fwd_rd_out), 32'd9);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_mem_valid", 32'(mem_valid_out), 32'd0);
      chk("arst_fwd_valid", 32'(fwd_valid_out), 32'd0);
      chk("arst_stall", 32'(stall_cnt_out), 32'd0);
      chk("arst_ready", 32'(ex_ready_out), 32'd1);
      chk("arst_payload", mem_alu_result_out, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      tick();
      chk("post_rst_empty", 32'(mem_valid_out), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   // Protocol guard: skid full must always deassert ready
   always @(negedge clk) begin
      if (rst_n && dut.s_valid_q && dut.h_valid_q && ex_ready_out)
         $display("FAIL ready_while_full observed=1 expected=0");
   end

endmodule
